// File: rtl/uart_alu_interface_if.sv
// Bundle of UART receiver, ALU and UART transmitter signals around the command sequencer.
// Latency: none, wires only.
// Backpressure: none; RX/TX use single-cycle done/start pulses.
interface uart_alu_interface_if #(
  parameter int NB_INTERFACE_DATA = 8,
  parameter int NB_INTERFACE_OP   = 6
);
  logic                         i_interface_RXDONE;
  logic [NB_INTERFACE_DATA-1:0] i_interface_RXDATA;
  logic [NB_INTERFACE_DATA-1:0] i_interface_ALURESULT;
  logic                         i_interface_TXDONE;
  logic [NB_INTERFACE_DATA-1:0] o_interface_DATAA;
  logic [NB_INTERFACE_DATA-1:0] o_interface_DATAB;
  logic [NB_INTERFACE_OP-1:0]   o_interface_OP;
  logic [NB_INTERFACE_DATA-1:0] o_interface_TXDATA;
  logic                         o_interface_TXSTART;
  logic                         o_interface_BUSY;
  logic                         o_interface_ERROR;
  logic [1:0]                   o_interface_ERRCODE;

  // Sequencer side
  modport slave (
    input  i_interface_RXDONE, i_interface_RXDATA, i_interface_ALURESULT, i_interface_TXDONE,
    output o_interface_DATAA, o_interface_DATAB, o_interface_OP, o_interface_TXDATA,
    output o_interface_TXSTART, o_interface_BUSY, o_interface_ERROR, o_interface_ERRCODE
  );

  // Environment side (UART RX/TX and ALU)
  modport master (
    output i_interface_RXDONE, i_interface_RXDATA, i_interface_ALURESULT, i_interface_TXDONE,
    input  o_interface_DATAA, o_interface_DATAB, o_interface_OP, o_interface_TXDATA,
    input  o_interface_TXSTART, o_interface_BUSY, o_interface_ERROR, o_interface_ERRCODE
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Command sequencer: collects A, B, opcode bytes from UART RX, drives the ALU, sends result to UART TX.
// Latency: opcode byte sampled at edge k -> TXDATA at k+1, TXSTART high from k+2 to k+3.
// Backpressure: none on RX; bytes arriving while a result is in flight are dropped and flagged as overrun.
module uart_alu_interface #(
  parameter int NB_INTERFACE_DATA = 8,
  parameter int NB_INTERFACE_OP   = 6,
  parameter int TIMEOUT_CYCLES    = 1_000_000
) (
  input logic                  i_clk,
  input logic                  i_reset,
  uart_alu_interface_if.slave  bus
);

  localparam int NBD = NB_INTERFACE_DATA;
  localparam int NBO = NB_INTERFACE_OP;
  localparam int NBT = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NBT-1:0] TERM_CNT = NBT'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_BAD_OP  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  state_t           state_q;
  logic [NBT-1:0]   cnt_q;
  logic [NBD-1:0]   dataa_q;
  logic [NBD-1:0]   datab_q;
  logic [NBO-1:0]   op_q;
  logic [NBD-1:0]   txdata_q;
  logic             txstart_q;
  logic             busy_q;
  logic             error_q;
  logic [1:0]       errcode_q;

  logic             rx_vld;
  logic [NBD-1:0]   rx_dat;
  logic [NBO-1:0]   rx_op;
  logic             op_valid;

  assign rx_vld = bus.i_interface_RXDONE;
  assign rx_dat = bus.i_interface_RXDATA;
  assign rx_op  = rx_dat[NBO-1:0];

  // Opcode whitelist: ADD SUB AND OR XOR NOR SRA SRL
  always_comb begin
    op_valid = 1'b0;
    case (rx_op)
      NBO'(6'b100000), NBO'(6'b100010), NBO'(6'b100100), NBO'(6'b100101),
      NBO'(6'b100110), NBO'(6'b100111), NBO'(6'b000011), NBO'(6'b000010): op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  // Frame sequencer with registered outputs; ERROR and TXSTART are single-cycle pulses
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dataa_q   <= '0;
      datab_q   <= '0;
      op_q      <= '0;
      txdata_q  <= '0;
      txstart_q <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      errcode_q <= 2'b00;
    end else begin
      error_q   <= 1'b0;
      txstart_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rx_vld) begin
            dataa_q <= rx_dat;
            state_q <= ST_WAIT_B;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT_B: begin
          // A byte arriving on the terminal count still wins over the timeout
          if (rx_vld) begin
            datab_q <= rx_dat;
            state_q <= ST_WAIT_OP;
            cnt_q   <= '0;
          end else if (cnt_q == TERM_CNT) begin
            error_q   <= 1'b1;
            errcode_q <= ERR_TIMEOUT;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_OP: begin
          if (rx_vld) begin
            cnt_q <= '0;
            if (op_valid) begin
              op_q    <= rx_op;
              state_q <= ST_EXEC;
            end else begin
              error_q   <= 1'b1;
              errcode_q <= ERR_BAD_OP;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end
          end else if (cnt_q == TERM_CNT) begin
            error_q   <= 1'b1;
            errcode_q <= ERR_TIMEOUT;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_EXEC: begin
          // Operands were registered last cycle, so the ALU output is settled now
          txdata_q <= bus.i_interface_ALURESULT;
          state_q  <= ST_SEND;
          if (rx_vld) begin
            error_q   <= 1'b1;
            errcode_q <= ERR_OVERRUN;
          end
        end
        ST_SEND: begin
          txstart_q <= 1'b1;
          state_q   <= ST_WAIT_TX;
          if (rx_vld) begin
            error_q   <= 1'b1;
            errcode_q <= ERR_OVERRUN;
          end
        end
        ST_WAIT_TX: begin
          if (bus.i_interface_TXDONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          if (rx_vld) begin
            error_q   <= 1'b1;
            errcode_q <= ERR_OVERRUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.o_interface_DATAA   = dataa_q;
  assign bus.o_interface_DATAB   = datab_q;
  assign bus.o_interface_OP      = op_q;
  assign bus.o_interface_TXDATA  = txdata_q;
  assign bus.o_interface_TXSTART = txstart_q;
  assign bus.o_interface_BUSY    = busy_q;
  assign bus.o_interface_ERROR   = error_q;
  assign bus.o_interface_ERRCODE = errcode_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small behavioural ALU on the result input.
// Latency: checks TXSTART two edges after the opcode byte and timeout after 16 clocks.
// Backpressure: exercises overrun by sending a byte while waiting for TXDONE.
module tb_uart_alu_interface;

  logic i_clk;
  logic i_reset;
  int   n_total;
  int   n_pass;
  int   n_txstart;
  int   n_error;

  uart_alu_interface_if #(.NB_INTERFACE_DATA(8), .NB_INTERFACE_OP(6)) bus ();

  uart_alu_interface #(
    .NB_INTERFACE_DATA(8),
    .NB_INTERFACE_OP  (6),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   alu = a + b;
      6'h22:   alu = a - b;
      6'h24:   alu = a & b;
      6'h25:   alu = a | b;
      6'h26:   alu = a ^ b;
      6'h27:   alu = ~(a | b);
      6'h03:   alu = $unsigned($signed(a) >>> b[2:0]);
      6'h02:   alu = a >> b[2:0];
      default: alu = 8'h00;
    endcase
  endfunction

  assign bus.i_interface_ALURESULT = alu(bus.o_interface_DATAA, bus.o_interface_DATAB, bus.o_interface_OP);

  // Pulse monitors, sampled away from the active edge
  always @(negedge i_clk) begin
    if (bus.o_interface_TXSTART === 1'b1) n_txstart++;
    if (bus.o_interface_ERROR === 1'b1)   n_error++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; the byte is sampled on the next rising edge, returns at the following negedge
  task automatic send_byte(input logic [7:0] b);
    bus.i_interface_RXDATA = b;
    bus.i_interface_RXDONE = 1'b1;
    @(negedge i_clk);
    bus.i_interface_RXDONE = 1'b0;
  endtask

  task automatic pulse_txdone();
    bus.i_interface_TXDONE = 1'b1;
    @(negedge i_clk);
    bus.i_interface_TXDONE = 1'b0;
  endtask

  // Sends a full frame and returns at the negedge where TXSTART is seen (state WAIT_TX)
  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic seen;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge i_clk);
      if (bus.o_interface_TXSTART === 1'b1) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int tx0;
    int er0;
    n_total = 0;
    n_pass  = 0;
    n_txstart = 0;
    n_error   = 0;
    bus.i_interface_RXDONE = 1'b0;
    bus.i_interface_RXDATA = 8'h00;
    bus.i_interface_TXDONE = 1'b0;
    i_reset = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_data", {bus.o_interface_DATAA, bus.o_interface_DATAB, bus.o_interface_TXDATA}, 32'h0);
    check("rst_ctl", {bus.o_interface_OP, bus.o_interface_TXSTART, bus.o_interface_BUSY,
                      bus.o_interface_ERROR, bus.o_interface_ERRCODE}, 32'h0);
    i_reset = 1'b1;
    repeat (10) @(negedge i_clk);
    check("idle_out", {bus.o_interface_DATAA, bus.o_interface_DATAB, bus.o_interface_OP,
                       bus.o_interface_BUSY, bus.o_interface_ERRCODE}, 32'h0);

    // ADD frame with exact TXSTART timing
    send_byte(8'h05);
    check("add_busy_a", {31'd0, bus.o_interface_BUSY}, 32'd1);
    check("add_dataa", {24'd0, bus.o_interface_DATAA}, 32'h05);
    send_byte(8'h03);
    tx0 = n_txstart;
    send_byte(8'h20);
    check("add_txstart_k", {31'd0, bus.o_interface_TXSTART}, 32'd0);
    @(negedge i_clk);
    check("add_txstart_k1", {31'd0, bus.o_interface_TXSTART}, 32'd0);
    check("add_txdata", {24'd0, bus.o_interface_TXDATA}, 32'h08);
    @(negedge i_clk);
    check("add_txstart_k2", {31'd0, bus.o_interface_TXSTART}, 32'd1);
    @(negedge i_clk);
    check("add_txstart_k3", {31'd0, bus.o_interface_TXSTART}, 32'd0);
    repeat (3) @(negedge i_clk);
    check("add_busy_wait", {31'd0, bus.o_interface_BUSY}, 32'd1);
    check("add_regs", {8'd0, bus.o_interface_DATAB, 2'b00, bus.o_interface_OP, bus.o_interface_TXDATA},
          32'h0003_2008);
    check("add_one_start", n_txstart - tx0, 32'd1);
    pulse_txdone();
    check("add_busy_done", {31'd0, bus.o_interface_BUSY}, 32'd0);

    // Bad opcode
    tx0 = n_txstart;
    er0 = n_error;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
    check("bad_err", {29'd0, bus.o_interface_ERROR, bus.o_interface_ERRCODE}, 32'b101);
    check("bad_busy", {31'd0, bus.o_interface_BUSY}, 32'd0);
    repeat (4) @(negedge i_clk);
    check("bad_one_err", n_error - er0, 32'd1);
    check("bad_no_start", n_txstart - tx0, 32'd0);
    check("bad_op_kept", {26'd0, bus.o_interface_OP}, 32'h20);

    // Timeout after 16 clocks of silence in WAIT_B
    send_byte(8'hAA);
    repeat (15) @(negedge i_clk);
    check("to_pre", {30'd0, bus.o_interface_ERROR, bus.o_interface_BUSY}, 32'b01);
    @(negedge i_clk);
    check("to_err", {29'd0, bus.o_interface_ERROR, bus.o_interface_ERRCODE}, 32'b110);
    check("to_busy", {31'd0, bus.o_interface_BUSY}, 32'd0);
    check("to_keep", {16'd0, bus.o_interface_DATAA, bus.o_interface_DATAB}, 32'hAA02);
    @(negedge i_clk);
    send_frame("sub_start", 8'h04, 8'h02, 8'h22);
    check("sub_txdata", {24'd0, bus.o_interface_TXDATA}, 32'h02);
    check("sticky_code", {30'd0, bus.o_interface_ERRCODE}, 32'b10);
    pulse_txdone();

    // Byte on the terminal count wins over the timeout
    er0 = n_error;
    send_byte(8'h11);
    repeat (15) @(negedge i_clk);
    send_byte(8'h22);
    check("term_byte", {16'd0, bus.o_interface_DATAB, 7'd0, bus.o_interface_BUSY}, 32'h2201);
    check("term_no_err", n_error - er0, 32'd0);
    send_byte(8'h26);
    repeat (2) @(negedge i_clk);
    check("xor_txdata", {24'd0, bus.o_interface_TXDATA}, 32'h33);
    pulse_txdone();

    // Overrun while waiting for TXDONE
    send_frame("ovr_start", 8'h09, 8'h01, 8'h20);
    send_byte(8'h77);
    check("ovr_err", {29'd0, bus.o_interface_ERROR, bus.o_interface_ERRCODE}, 32'b111);
    check("ovr_keep", {8'd0, bus.o_interface_DATAA, bus.o_interface_TXDATA, 7'd0, bus.o_interface_BUSY},
          32'h00_090A_01);
    pulse_txdone();
    check("ovr_idle", {31'd0, bus.o_interface_BUSY}, 32'd0);
    send_byte(8'h33);
    check("ovr_next_a", {24'd0, bus.o_interface_DATAA}, 32'h33);

    // Asynchronous reset between A and B
    #2 i_reset = 1'b0;
    #1;
    check("arst_clear", {bus.o_interface_DATAA, 7'd0, bus.o_interface_BUSY, 14'd0, bus.o_interface_ERRCODE},
          32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    send_frame("or_start", 8'h0F, 8'hF0, 8'h25);
    check("or_txdata", {24'd0, bus.o_interface_TXDATA}, 32'hFF);
    pulse_txdone();
    check("or_idle", {31'd0, bus.o_interface_BUSY}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
